// File: rtl/pipeline_pkg.sv
// Types and constants shared by the pipeline hazard/stall control logic.
package pipeline_pkg;
   localparam int REG_ADDR_W = 4;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_WAIT = 2'd1,
      HALT    = 2'd2
   } ctrl_state_e;
endpackage

// File: rtl/pipeline_stall_controller_load_use_detect.sv
// Flags a load in EX whose destination feeds a source operand of the ID instruction.
module load_use_detect
   import pipeline_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] id_op1,
   input  logic [REG_ADDR_W-1:0] id_op2,
   input  logic                  id_uses_op2,
   input  logic [REG_ADDR_W-1:0] ex_dest,
   input  logic                  ex_mem_read,
   output logic                  load_use
);
   // r0 is deliberately not excluded: the register file treats it as a normal register.
   assign load_use = ex_mem_read &
                     ((ex_dest == id_op1) | (id_uses_op2 & (ex_dest == id_op2)));
endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline sequencing around load-use, taken branch, multi-cycle mul/div and halt.
module pipeline_stall_controller
   import pipeline_pkg::*;
#(
   parameter int MULDIV_CYCLES = 4,
   parameter int STALL_CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [REG_ADDR_W-1:0]  id_op1,
   input  logic [REG_ADDR_W-1:0]  id_op2,
   input  logic                   id_uses_op2,
   input  logic [REG_ADDR_W-1:0]  ex_dest,
   input  logic                   ex_mem_read,
   input  logic                   id_branch_taken,
   input  logic                   id_muldiv,
   input  logic                   id_halt,
   output logic                   pc_we,
   output logic                   ifid_we,
   output logic                   ifid_flush,
   output logic                   idex_bubble,
   output logic                   ex_hold,
   output logic                   exmem_bubble,
   output logic                   muldiv_busy,
   output logic                   halted,
   output logic [STALL_CNT_W-1:0] stall_count
);
   ctrl_state_e            state_q, state_d;
   logic [3:0]             md_cnt_q, md_cnt_d;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;
   logic                   load_use;

   load_use_detect u_lud (
      .id_op1      (id_op1),
      .id_op2      (id_op2),
      .id_uses_op2 (id_uses_op2),
      .ex_dest     (ex_dest),
      .ex_mem_read (ex_mem_read),
      .load_use    (load_use)
   );

   always_comb begin
      state_d      = state_q;
      md_cnt_d     = md_cnt_q;
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      ex_hold      = 1'b0;
      exmem_bubble = 1'b0;
      muldiv_busy  = 1'b0;
      halted       = 1'b0;
      if (rst) begin
         state_d      = RUN;
         md_cnt_d     = 4'd0;
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         exmem_bubble = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (load_use) begin
                  idex_bubble = 1'b1;
               end else if (id_halt) begin
                  idex_bubble = 1'b1;
                  state_d     = HALT;
               end else if (id_branch_taken) begin
                  pc_we      = 1'b1;
                  ifid_we    = 1'b1;
                  ifid_flush = 1'b1;
               end else begin
                  pc_we   = 1'b1;
                  ifid_we = 1'b1;
                  if (id_muldiv) begin
                     state_d  = MD_WAIT;
                     md_cnt_d = 4'(MULDIV_CYCLES - 1);
                  end
               end
            end
            MD_WAIT: begin
               ex_hold      = 1'b1;
               exmem_bubble = 1'b1;
               muldiv_busy  = 1'b1;
               md_cnt_d     = md_cnt_q - 4'd1;
               if (md_cnt_q == 4'd1) state_d = RUN;
            end
            HALT: begin
               idex_bubble = 1'b1;
               halted      = 1'b1;
            end
            default: state_d = RUN;
         endcase
      end
   end

   // Stall cycles counted only outside HALT so a halted core shows a frozen count.
   always_comb begin
      stall_d = stall_q;
      if (rst) stall_d = '0;
      else if (!pc_we && state_q != HALT && stall_q != '1)
         stall_d = stall_q + STALL_CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      stall_q  <= stall_d;
   end

   assign stall_count = stall_q;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed vector table, saturation run, random vs model.
module tb_pipeline_stall_controller;
   localparam int MDC = 4;
   localparam int SCW = 5;

   typedef struct packed {
      logic       rst;
      logic [3:0] op1;
      logic [3:0] op2;
      logic       uses2;
      logic [3:0] dest;
      logic       memrd;
      logic       br;
      logic       md;
      logic       halt;
   } vin_t;

   // ctl = {pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, exmem_bubble, muldiv_busy, halted}
   typedef struct packed {
      vin_t       in;
      logic [7:0] ctl;
      int         cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic [3:0] id_op1, id_op2, ex_dest;
   logic id_uses_op2, ex_mem_read, id_branch_taken, id_muldiv, id_halt;
   logic pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, exmem_bubble, muldiv_busy, halted;
   logic [SCW-1:0] stall_count;

   int errors = 0;
   int checks = 0;

   // reference model state
   int m_md_left;
   bit m_halted;
   int m_cnt;

   always #5 clk = ~clk;

   pipeline_stall_controller #(.MULDIV_CYCLES(MDC), .STALL_CNT_W(SCW)) dut (
      .clk(clk), .rst(rst), .id_op1(id_op1), .id_op2(id_op2), .id_uses_op2(id_uses_op2),
      .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .id_branch_taken(id_branch_taken),
      .id_muldiv(id_muldiv), .id_halt(id_halt), .pc_we(pc_we), .ifid_we(ifid_we),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .ex_hold(ex_hold),
      .exmem_bubble(exmem_bubble), .muldiv_busy(muldiv_busy), .halted(halted),
      .stall_count(stall_count)
   );

   function automatic logic [7:0] model_ctl(input vin_t v);
      bit lu;
      lu = v.memrd && (v.dest == v.op1 || (v.uses2 && v.dest == v.op2));
      if (v.rst)             return 8'b0011_0100;
      if (m_halted)          return 8'b0001_0001;
      if (m_md_left > 0)     return 8'b0000_1110;
      if (lu || v.halt)      return 8'b0001_0000;
      if (v.br)              return 8'b1110_0000;
      return 8'b1100_0000;
   endfunction

   task automatic model_advance(input vin_t v, input logic [7:0] c);
      bit lu;
      lu = v.memrd && (v.dest == v.op1 || (v.uses2 && v.dest == v.op2));
      if (v.rst) begin
         m_md_left = 0; m_halted = 0; m_cnt = 0;
      end else begin
         if (!c[7] && !m_halted && m_cnt < (1 << SCW) - 1) m_cnt++;
         if (m_halted) ;
         else if (m_md_left > 0) m_md_left--;
         else if (lu) ;
         else if (v.halt) m_halted = 1;
         else if (!v.br && v.md) m_md_left = MDC - 1;
      end
   endtask

   function automatic logic [7:0] dut_ctl();
      return {pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, exmem_bubble, muldiv_busy, halted};
   endfunction

   // Applies one cycle of inputs; checks against the model (and an optional table row) mid-cycle.
   task automatic step(input vin_t v, input bit tbl, input logic [7:0] t_ctl, input int t_cnt,
                       input int idx);
      logic [7:0] e;
      rst = v.rst; id_op1 = v.op1; id_op2 = v.op2; id_uses_op2 = v.uses2; ex_dest = v.dest;
      ex_mem_read = v.memrd; id_branch_taken = v.br; id_muldiv = v.md; id_halt = v.halt;
      @(negedge clk);
      e = model_ctl(v);
      checks++;
      if (dut_ctl() !== e || int'(stall_count) != m_cnt) begin
         errors++;
         $display("FAIL model step %0d: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                  idx, dut_ctl(), stall_count, e, m_cnt);
      end
      if (tbl) begin
         checks++;
         if (dut_ctl() !== t_ctl || int'(stall_count) != t_cnt) begin
            errors++;
            $display("FAIL vector %0d: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                     idx, dut_ctl(), stall_count, t_ctl, t_cnt);
         end
      end
      @(posedge clk);
      model_advance(v, e);
      #1;
   endtask

   function automatic vin_t mk(input logic r, input logic [3:0] o1, input logic [3:0] o2,
                               input logic u2, input logic [3:0] d, input logic mr,
                               input logic b, input logic m, input logic h);
      vin_t v;
      v.rst = r; v.op1 = o1; v.op2 = o2; v.uses2 = u2; v.dest = d; v.memrd = mr;
      v.br = b; v.md = m; v.halt = h;
      return v;
   endfunction

   localparam logic [7:0] C_RST  = 8'b0011_0100;
   localparam logic [7:0] C_RUN  = 8'b1100_0000;
   localparam logic [7:0] C_STL  = 8'b0001_0000;
   localparam logic [7:0] C_MD   = 8'b0000_1110;
   localparam logic [7:0] C_BR   = 8'b1110_0000;
   localparam logic [7:0] C_HLT  = 8'b0001_0001;

   vec_t tbl [$];

   initial begin
      vin_t idle, v;
      idle = mk(0, 4'd1, 4'd2, 1, 4'd9, 0, 0, 0, 0);
      m_md_left = 0; m_halted = 0; m_cnt = 0;
      rst = 1; id_op1 = 0; id_op2 = 0; id_uses_op2 = 0; ex_dest = 0;
      ex_mem_read = 0; id_branch_taken = 0; id_muldiv = 0; id_halt = 0;
      @(posedge clk); #1;

      tbl.push_back('{mk(1, 1, 2, 1, 9, 0, 0, 0, 0), C_RST, 0});   // reset
      tbl.push_back('{idle, C_RUN, 0});
      tbl.push_back('{mk(0, 5, 2, 1, 5, 1, 0, 0, 0), C_STL, 0});   // load-use op1
      tbl.push_back('{idle, C_RUN, 1});
      tbl.push_back('{mk(0, 0, 3, 0, 3, 1, 0, 0, 0), C_RUN, 1});   // op2 unused
      tbl.push_back('{mk(0, 1, 2, 1, 9, 0, 0, 1, 0), C_RUN, 1});   // muldiv issue
      tbl.push_back('{idle, C_MD, 1});
      tbl.push_back('{idle, C_MD, 2});
      tbl.push_back('{idle, C_MD, 3});
      tbl.push_back('{idle, C_RUN, 4});
      tbl.push_back('{mk(0, 1, 7, 1, 7, 1, 1, 0, 0), C_STL, 4});   // load-use beats branch
      tbl.push_back('{mk(0, 1, 7, 1, 9, 0, 1, 0, 0), C_BR, 5});
      tbl.push_back('{mk(0, 1, 2, 1, 9, 0, 0, 0, 1), C_STL, 5});   // halt
      tbl.push_back('{idle, C_HLT, 6});
      tbl.push_back('{mk(0, 1, 2, 1, 9, 0, 1, 1, 0), C_HLT, 6});
      tbl.push_back('{mk(1, 1, 2, 1, 9, 0, 0, 0, 0), C_RST, 6});
      tbl.push_back('{idle, C_RUN, 0});
      tbl.push_back('{mk(0, 1, 2, 1, 9, 0, 0, 1, 0), C_RUN, 0});
      tbl.push_back('{idle, C_MD, 0});
      tbl.push_back('{mk(1, 1, 2, 1, 9, 0, 0, 0, 0), C_RST, 1});   // reset mid MD_WAIT
      tbl.push_back('{idle, C_RUN, 0});
      tbl.push_back('{mk(0, 0, 2, 1, 0, 1, 0, 0, 0), C_STL, 0});   // r0 load-use
      tbl.push_back('{mk(0, 1, 2, 1, 9, 0, 0, 1, 0), C_RUN, 1});   // back-to-back muldiv
      tbl.push_back('{mk(0, 1, 2, 1, 9, 0, 0, 1, 0), C_MD, 1});
      tbl.push_back('{mk(0, 1, 2, 1, 9, 0, 0, 1, 0), C_MD, 2});
      tbl.push_back('{mk(0, 1, 2, 1, 9, 0, 0, 1, 0), C_MD, 3});
      tbl.push_back('{mk(0, 1, 2, 1, 9, 0, 0, 1, 0), C_RUN, 4});
      tbl.push_back('{mk(0, 1, 2, 1, 9, 0, 1, 0, 0), C_MD, 4});    // branch waits out MD
      tbl.push_back('{mk(0, 1, 2, 1, 9, 0, 1, 0, 0), C_MD, 5});
      tbl.push_back('{mk(0, 1, 2, 1, 9, 0, 1, 0, 0), C_MD, 6});
      tbl.push_back('{mk(0, 1, 2, 1, 9, 0, 1, 0, 0), C_BR, 7});

      foreach (tbl[i]) step(tbl[i].in, 1'b1, tbl[i].ctl, tbl[i].cnt, i);

      // saturation: hold a load-use hazard well past the counter range
      step(mk(1, 1, 2, 1, 9, 0, 0, 0, 0), 1'b0, '0, 0, 100);
      for (int i = 0; i < 40; i++) step(mk(0, 6, 2, 1, 6, 1, 0, 0, 0), 1'b0, '0, 0, 200 + i);
      step(idle, 1'b1, C_RUN, (1 << SCW) - 1, 300);

      // randomized traffic with small register range so hazards are frequent
      for (int i = 0; i < 600; i++) begin
         v = mk(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                1'($urandom), 4'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 30) == 0));
         step(v, 1'b0, '0, 0, 1000 + i);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
